cache_control: RTL
==================

// Module: cache_control
// PURPOSE
//  Control FSM for the 2-way set-associative, write-back, write-allocate L1 cache.
//  Sits between the CPU memory port and the cache datapath. Sequences hits, victim writebacks and line fills.
//  Drives every datapath write-enable and mux select.
//  Keeps saturating hit/miss/writeback statistics counters for performance runs.
// PARAMETERS
//  CNT_WIDTH  16  width of each statistics counter
// PORTS
//  clk             in   1          clock; all state updates on the rising edge
//  reset           in   1          synchronous, active-high reset
//  mem_read        in   1          CPU read request; held high until mem_resp
//  mem_write       in   1          CPU write request; held high until mem_resp; never with mem_read
//  mem_resp        out  1          request complete, one-cycle pulse
//  hit0, hit1      in   1          way 0/1 tag match and valid (combinational from datapath)
//  lru_out         in   1          LRU way of the indexed set (0 = way 0 is victim)
//  dirty_out0/1    in   1          dirty bit of way 0/1 for the indexed set
//  pmem_read       out  1          physical memory line read request
//  pmem_write      out  1          physical memory line write request
//  pmem_resp       in   1          physical memory done; one cycle
//  inmux_sel       out  1          0 = fill from pmem_rdata; 1 = merged CPU write data
//  addrmux_sel     out  2          0 = mem_address; 1 = {tag0,index,0}; 2 = {tag1,index,0}; 3 = unused
//  data0/1_write   out  1          data way write enable
//  tag0/1_write    out  1          tag way write enable
//  valid0/1_write  out  1          valid way write enable (datapath writes 1)
//  dirty0/1_write  out  1          dirty way write enable (datapath writes mem_write)
//  lru_write       out  1          LRU write enable (datapath writes hit0)
//  stats_clear     in   1          synchronous clear of all counters
//  hit_count       out  CNT_WIDTH  requests served without a fill
//  miss_count      out  CNT_WIDTH  requests that required a fill
//  wb_count        out  CNT_WIDTH  dirty victim writebacks completed
// BEHAVIOUR
//  Array semantics: arrays read combinationally and write on the clk edge when enabled.
//  Output defaults: all outputs are Moore/Mealy decodes of the state and default to 0.
//   - addrmux_sel defaults to 0.
//   - With reset asserted, or in IDLE with no request, every output is 0.
//  State register and the refill flag reset to IDLE/0. Counters reset to 0.
//  States:
//   - IDLE: req = mem_read | mem_write.
//     - req & (hit0|hit1): mem_resp=1 and lru_write=1 (same-cycle response, 0 wait states).
//       On mem_write, also data<h>_write=1, dirty<h>_write=1 and inmux_sel=1 (h = hitting way).
//       Stay in IDLE.
//     - req & miss: victim v = lru_out. Go to WRITEBACK if dirty_out<v>, else FETCH. No outputs.
//   - WRITEBACK: pmem_write=1, addrmux_sel = v ? 2 : 1.
//     Hold until pmem_resp, then go to FETCH.
//   - FETCH: pmem_read=1, addrmux_sel=0.
//     On pmem_resp: data<v>_write, tag<v>_write, valid<v>_write and dirty<v>_write = 1, inmux_sel=0.
//     Set refill=1 and go to IDLE.
//     The re-check in IDLE then hits and completes the request, including any write merge.
//  v is recomputed from lru_out each cycle. LRU and index are stable while the request is held, so v is constant through a miss.
//  Both ways hitting cannot occur; if it does, way 0 has priority.
//  Counters (saturate at all-ones, never wrap):
//   - hit_count +1 on the IDLE hit cycle only when refill=0.
//   - miss_count +1 on the IDLE->WRITEBACK/FETCH transition.
//   - wb_count +1 on the WRITEBACK pmem_resp cycle.
//   - refill clears on any mem_resp.
//   - stats_clear has priority over increments in the same cycle.
//  pmem_resp outside WRITEBACK/FETCH is ignored.
//  Reset mid-miss: FSM returns to IDLE next edge and pmem_read/pmem_write drop.
//   - No array write occurs in that cycle.
//   - The abandoned line is not partially written.
// TESTING
//  1. Read miss, clean victim (lru_out=0): FETCH with pmem_read=1, addrmux_sel=0; pmem_resp after 5 cycles
//     -> way 0 data/tag/valid/dirty written; next cycle mem_resp=1; miss_count=1, hit_count=0.
//  2. Write hit on way 1 (hit1=1), byte enable 2'b01
//     -> same cycle: mem_resp=1, data1_write=1, dirty1_write=1, inmux_sel=1, lru_write=1; hit_count+1.
//  3. Miss with lru_out=1, dirty_out1=1
//     -> WRITEBACK with pmem_write=1, addrmux_sel=2; on pmem_resp go to FETCH; wb_count=1.
//     After fill, mem_resp is asserted exactly once.
//  4. reset high for 1 cycle during FETCH while pmem_read=1
//     -> next cycle all outputs 0; no *_write pulse; state IDLE.
//  5. Preload hit_count=16'hFFFE, then issue 3 hits -> hit_count holds 16'hFFFF.
//     stats_clear together with a hit -> 0.
//  6. 1000 random read/write requests vs a reference cache model
//     -> mem_rdata matches, and hit_count + miss_count == 1000.

Source files
------------

// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative, write-back, write-allocate L1 cache.
// Sequences hits, dirty-victim writebacks and line fills; keeps saturating statistics.
module cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  input  logic                 hit0,
  input  logic                 hit1,
  input  logic                 lru_out,
  input  logic                 dirty_out0,
  input  logic                 dirty_out1,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  output logic                 inmux_sel,
  output logic [1:0]           addrmux_sel,
  output logic                 data0_write,
  output logic                 data1_write,
  output logic                 tag0_write,
  output logic                 tag1_write,
  output logic                 valid0_write,
  output logic                 valid1_write,
  output logic                 dirty0_write,
  output logic                 dirty1_write,
  output logic                 lru_write,
  input  logic                 stats_clear,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_e;

  state_e               state_q, state_d;
  logic                 refill_q, refill_d;
  logic [CNT_WIDTH-1:0] hit_q, hit_d, miss_q, miss_d, wb_q, wb_d;

  logic req;
  logic victim;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign req    = mem_read | mem_write;
  assign victim = lru_out;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d      = state_q;
    refill_d     = refill_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    wb_d         = wb_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    inmux_sel    = 1'b0;
    addrmux_sel  = 2'd0;
    data0_write  = 1'b0;
    data1_write  = 1'b0;
    tag0_write   = 1'b0;
    tag1_write   = 1'b0;
    valid0_write = 1'b0;
    valid1_write = 1'b0;
    dirty0_write = 1'b0;
    dirty1_write = 1'b0;
    lru_write    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req && (hit0 || hit1)) begin
          mem_resp  = 1'b1;
          lru_write = 1'b1;
          refill_d  = 1'b0;
          if (!refill_q) hit_d = sat_inc(hit_q);
          if (mem_write) begin
            // Way 0 wins if both ways ever claim a hit.
            inmux_sel    = 1'b1;
            data0_write  = hit0;
            dirty0_write = hit0;
            data1_write  = !hit0;
            dirty1_write = !hit0;
          end
        end else if (req) begin
          miss_d  = sat_inc(miss_q);
          state_d = (victim ? dirty_out1 : dirty_out0) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        pmem_write  = 1'b1;
        addrmux_sel = victim ? 2'd2 : 2'd1;
        if (pmem_resp) begin
          wb_d    = sat_inc(wb_q);
          state_d = FETCH;
        end
      end
      FETCH: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          data0_write  = !victim;
          tag0_write   = !victim;
          valid0_write = !victim;
          dirty0_write = !victim;
          data1_write  = victim;
          tag1_write   = victim;
          valid1_write = victim;
          dirty1_write = victim;
          refill_d     = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (stats_clear) begin
      hit_d  = '0;
      miss_d = '0;
      wb_d   = '0;
    end

    // Reset silences every strobe in the same cycle so an abandoned fill writes nothing.
    if (reset) begin
      mem_resp     = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      inmux_sel    = 1'b0;
      addrmux_sel  = 2'd0;
      data0_write  = 1'b0;
      data1_write  = 1'b0;
      tag0_write   = 1'b0;
      tag1_write   = 1'b0;
      valid0_write = 1'b0;
      valid1_write = 1'b0;
      dirty0_write = 1'b0;
      dirty1_write = 1'b0;
      lru_write    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      refill_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
      wb_q     <= '0;
    end else begin
      state_q  <= state_d;
      refill_q <= refill_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      wb_q     <= wb_d;
    end
  end

  assign hit_count  = reset ? '0 : hit_q;
  assign miss_count = reset ? '0 : miss_q;
  assign wb_count   = reset ? '0 : wb_q;

endmodule
